// File: rtl/pwm_capture.sv
// pwm_capture: measures the high time of a 255-cycle PWM frame on PWM_IN,
// flags stuck-high / stuck-low inputs and period deviations.
//
// state   | meaning
// --------+------------------------------------------------------------
// IDLE    | capture disabled, counters and outputs cleared
// SYNC    | waiting for the first rise to align to a frame boundary
// MEASURE | counting period and high time, reporting on each rise
module pwm_capture (
   input  logic       CLK,
   input  logic       RST_N,
   input  logic       E,
   input  logic       PWM_IN,
   output logic [7:0] DUTY,
   output logic       VALID,
   output logic       FULL,
   output logic       ZERO,
   output logic       PERIOD_ERR
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      MEASURE = 2'd2
   } state_t;

   state_t     state;
   state_t     state_nxt;

   logic       pwm_m;
   logic       pwm_s;
   logic       pwm_d;
   logic       rise;
   logic       trans;
   logic       stuck;

   logic [8:0] per_cnt;
   logic [7:0] hi_cnt;
   logic [8:0] run_cnt;

   assign rise  = pwm_s & ~pwm_d;
   assign trans = pwm_s ^ pwm_d;

   // run_cnt excludes the transition cycle itself, so a value of 254 on a
   // non-transition cycle means the level has held for 255 cycles. The
   // !trans term also makes stuck and rise mutually exclusive.
   assign stuck = (state != IDLE) && !trans && (run_cnt == 9'd254);

   // Two-flop synchronizer plus one delay stage for edge detection
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         pwm_m <= 1'b0;
         pwm_s <= 1'b0;
         pwm_d <= 1'b0;
      end else begin
         pwm_m <= PWM_IN;
         pwm_s <= pwm_m;
         pwm_d <= pwm_s;
      end
   end

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic; stuck detection wins over rise
   always_comb begin
      state_nxt = state;
      if (!E) begin
         state_nxt = IDLE;
      end else begin
         case (state)
            IDLE:    state_nxt = SYNC;
            SYNC: begin
               if (stuck) begin
                  state_nxt = SYNC;
               end else if (rise) begin
                  state_nxt = MEASURE;
               end
            end
            MEASURE: begin
               if (stuck) begin
                  state_nxt = SYNC;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // Time since the last level change of the synchronized input
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         run_cnt <= 9'd0;
      end else if (!E || state == IDLE) begin
         run_cnt <= 9'd0;
      end else if (trans || stuck) begin
         run_cnt <= 9'd0;
      end else if (run_cnt != 9'd511) begin
         run_cnt <= run_cnt + 9'd1;
      end
   end

   // Period / high-time counters and the reported results
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         per_cnt    <= 9'd0;
         hi_cnt     <= 8'd0;
         DUTY       <= 8'd0;
         VALID      <= 1'b0;
         FULL       <= 1'b0;
         ZERO       <= 1'b0;
         PERIOD_ERR <= 1'b0;
      end else if (!E) begin
         per_cnt    <= 9'd0;
         hi_cnt     <= 8'd0;
         DUTY       <= 8'd0;
         VALID      <= 1'b0;
         FULL       <= 1'b0;
         ZERO       <= 1'b0;
         PERIOD_ERR <= 1'b0;
      end else begin
         VALID <= 1'b0;
         if (stuck) begin
            DUTY       <= {8{pwm_s}};
            FULL       <= pwm_s;
            ZERO       <= ~pwm_s;
            PERIOD_ERR <= 1'b0;
            VALID      <= 1'b1;
         end else if (rise && (state == SYNC || state == MEASURE)) begin
            // The rise cycle is itself the first high cycle of the new frame
            per_cnt <= 9'd1;
            hi_cnt  <= 8'd1;
            if (state == MEASURE) begin
               DUTY       <= hi_cnt;
               PERIOD_ERR <= (per_cnt != 9'd255);
               FULL       <= 1'b0;
               ZERO       <= 1'b0;
               VALID      <= 1'b1;
            end
         end else if (state == MEASURE) begin
            if (per_cnt != 9'd511) begin
               per_cnt <= per_cnt + 9'd1;
            end
            if (pwm_s && hi_cnt != 8'd255) begin
               hi_cnt <= hi_cnt + 8'd1;
            end
         end
      end
   end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed testbench for pwm_capture.
module tb_pwm_capture;

   logic       CLK;
   logic       RST_N;
   logic       E;
   logic       PWM_IN;
   logic [7:0] DUTY;
   logic       VALID;
   logic       FULL;
   logic       ZERO;
   logic       PERIOD_ERR;

   int errors    = 0;
   int checks    = 0;
   int cyc       = 0;
   int vcount    = 0;
   int last_vcyc = 0;
   int prev_vcyc = 0;
   int v0;

   pwm_capture dut (
      .CLK        (CLK),
      .RST_N      (RST_N),
      .E          (E),
      .PWM_IN     (PWM_IN),
      .DUTY       (DUTY),
      .VALID      (VALID),
      .FULL       (FULL),
      .ZERO       (ZERO),
      .PERIOD_ERR (PERIOD_ERR)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Cycle counter
   always @(posedge CLK) cyc <= cyc + 1;

   // Record each VALID pulse and when it happened
   always @(negedge CLK) begin
      if (VALID === 1'b1) begin
         vcount    = vcount + 1;
         prev_vcyc = last_vcyc;
         last_vcyc = cyc;
      end
   end

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic run(input logic v, input int n);
      PWM_IN = v;
      repeat (n) tick();
   endtask

   task automatic gen(input int period, input int high, input int frames);
      for (int f = 0; f < frames; f++) begin
         for (int i = 0; i < period; i++) begin
            PWM_IN = (i < high);
            tick();
         end
      end
   endtask

   task automatic check_all_zero(input string tag);
      checks++;
      if (DUTY !== 8'd0) begin
         errors++; $display("FAIL %s_duty: got %0d expected 0", tag, DUTY);
      end
      checks++;
      if (VALID !== 1'b0) begin
         errors++; $display("FAIL %s_valid: got %b expected 0", tag, VALID);
      end
      checks++;
      if (FULL !== 1'b0) begin
         errors++; $display("FAIL %s_full: got %b expected 0", tag, FULL);
      end
      checks++;
      if (ZERO !== 1'b0) begin
         errors++; $display("FAIL %s_zero: got %b expected 0", tag, ZERO);
      end
      checks++;
      if (PERIOD_ERR !== 1'b0) begin
         errors++; $display("FAIL %s_perr: got %b expected 0", tag, PERIOD_ERR);
      end
   endtask

   task automatic test_reset();
      RST_N  = 1'b0;
      E      = 1'b0;
      PWM_IN = 1'b0;
      #12;
      check_all_zero("reset");
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
   endtask

   task automatic test_j100();
      E = 1'b1;
      run(1'b0, 5);
      v0 = vcount;
      gen(255, 100, 4);
      checks++;
      if (vcount - v0 != 3) begin
         errors++; $display("FAIL j100_count: got %0d expected 3", vcount - v0);
      end
      checks++;
      if (DUTY !== 8'd100) begin
         errors++; $display("FAIL j100_duty: got %0d expected 100", DUTY);
      end
      checks++;
      if (PERIOD_ERR !== 1'b0) begin
         errors++; $display("FAIL j100_perr: got %b expected 0", PERIOD_ERR);
      end
      checks++;
      if (last_vcyc - prev_vcyc != 255) begin
         errors++; $display("FAIL j100_spacing: got %0d expected 255", last_vcyc - prev_vcyc);
      end
      checks++;
      if (FULL !== 1'b0 || ZERO !== 1'b0) begin
         errors++; $display("FAIL j100_flags: got full=%b zero=%b expected 0 0", FULL, ZERO);
      end
   endtask

   // VALID lands on the 3rd edge counting the one that first samples the rise
   task automatic test_latency();
      PWM_IN = 1'b1;
      tick();
      tick();
      checks++;
      if (VALID !== 1'b0) begin
         errors++; $display("FAIL latency_early: got %b expected 0", VALID);
      end
      tick();
      checks++;
      if (VALID !== 1'b1) begin
         errors++; $display("FAIL latency_valid: got %b expected 1", VALID);
      end
      checks++;
      if (DUTY !== 8'd100) begin
         errors++; $display("FAIL latency_duty: got %0d expected 100", DUTY);
      end
      run(1'b1, 97);
      run(1'b0, 50);
      checks++;
      if (DUTY !== 8'd100 || VALID !== 1'b0) begin
         errors++; $display("FAIL hold_duty: got duty=%0d valid=%b expected 100 0", DUTY, VALID);
      end
   endtask

   task automatic test_enable_drop();
      E = 1'b0;
      tick();
      check_all_zero("edrop");
      checks++;
      if (dut.state !== 2'd0) begin
         errors++; $display("FAIL edrop_state: got %0d expected 0", dut.state);
      end
      E = 1'b1;
      v0 = vcount;
      run(1'b0, 5);
      gen(255, 100, 1);
      checks++;
      if (vcount != v0) begin
         errors++; $display("FAIL reen_first_rise: got %0d pulses expected 0", vcount - v0);
      end
      gen(255, 100, 1);
      checks++;
      if (vcount - v0 != 1 || DUTY !== 8'd100) begin
         errors++; $display("FAIL reen_duty: got pulses=%0d duty=%0d expected 1 100", vcount - v0, DUTY);
      end
   endtask

   task automatic test_full();
      E = 1'b0;
      tick();
      E = 1'b1;
      run(1'b0, 5);
      v0 = vcount;
      run(1'b1, 600);
      checks++;
      if (vcount - v0 != 2) begin
         errors++; $display("FAIL full_count: got %0d expected 2", vcount - v0);
      end
      checks++;
      if (last_vcyc - prev_vcyc != 255) begin
         errors++; $display("FAIL full_spacing: got %0d expected 255", last_vcyc - prev_vcyc);
      end
      checks++;
      if (DUTY !== 8'd255) begin
         errors++; $display("FAIL full_duty: got %0d expected 255", DUTY);
      end
      checks++;
      if (FULL !== 1'b1 || ZERO !== 1'b0) begin
         errors++; $display("FAIL full_flags: got full=%b zero=%b expected 1 0", FULL, ZERO);
      end
      checks++;
      if (PERIOD_ERR !== 1'b0) begin
         errors++; $display("FAIL full_perr: got %b expected 0", PERIOD_ERR);
      end
   endtask

   task automatic test_zero();
      v0 = vcount;
      run(1'b0, 300);
      checks++;
      if (vcount - v0 != 1) begin
         errors++; $display("FAIL zero_count: got %0d expected 1", vcount - v0);
      end
      checks++;
      if (DUTY !== 8'd0) begin
         errors++; $display("FAIL zero_duty: got %0d expected 0", DUTY);
      end
      checks++;
      if (ZERO !== 1'b1 || FULL !== 1'b0) begin
         errors++; $display("FAIL zero_flags: got zero=%b full=%b expected 1 0", ZERO, FULL);
      end
      v0 = vcount;
      gen(255, 1, 3);
      checks++;
      if (vcount - v0 != 2) begin
         errors++; $display("FAIL j1_count: got %0d expected 2", vcount - v0);
      end
      checks++;
      if (DUTY !== 8'd1) begin
         errors++; $display("FAIL j1_duty: got %0d expected 1", DUTY);
      end
      checks++;
      if (ZERO !== 1'b0 || FULL !== 1'b0 || PERIOD_ERR !== 1'b0) begin
         errors++; $display("FAIL j1_flags: got zero=%b full=%b perr=%b expected 0 0 0", ZERO, FULL, PERIOD_ERR);
      end
   endtask

   task automatic test_period_err();
      v0 = vcount;
      gen(200, 50, 3);
      checks++;
      if (vcount - v0 != 3) begin
         errors++; $display("FAIL p200_count: got %0d expected 3", vcount - v0);
      end
      checks++;
      if (DUTY !== 8'd50) begin
         errors++; $display("FAIL p200_duty: got %0d expected 50", DUTY);
      end
      checks++;
      if (PERIOD_ERR !== 1'b1) begin
         errors++; $display("FAIL p200_perr: got %b expected 1", PERIOD_ERR);
      end
      checks++;
      if (last_vcyc - prev_vcyc != 200) begin
         errors++; $display("FAIL p200_spacing: got %0d expected 200", last_vcyc - prev_vcyc);
      end
   endtask

   task automatic test_async_reset();
      #2;
      RST_N = 1'b0;
      #1;
      check_all_zero("areset");
      checks++;
      if (dut.state !== 2'd0) begin
         errors++; $display("FAIL areset_state: got %0d expected 0", dut.state);
      end
      @(posedge CLK);
      #1;
      RST_N = 1'b1;
      run(1'b0, 3);
      v0 = vcount;
      gen(255, 254, 3);
      checks++;
      if (vcount - v0 != 2) begin
         errors++; $display("FAIL j254_count: got %0d expected 2", vcount - v0);
      end
      checks++;
      if (DUTY !== 8'd254) begin
         errors++; $display("FAIL j254_duty: got %0d expected 254", DUTY);
      end
      checks++;
      if (PERIOD_ERR !== 1'b0 || FULL !== 1'b0 || ZERO !== 1'b0) begin
         errors++; $display("FAIL j254_flags: got perr=%b full=%b zero=%b expected 0 0 0", PERIOD_ERR, FULL, ZERO);
      end
   endtask

   initial begin
      test_reset();
      test_j100();
      test_latency();
      test_enable_drop();
      test_full();
      test_zero();
      test_period_err();
      test_async_reset();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
